// File: rtl/tqvp_bus_arbiter.sv
// rtl/tqvp_bus_arbiter.sv - two-requester round-robin arbiter and sequencer for the TinyQV peripheral bus
module tqvp_bus_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [1:0]        m0_txn,
    output logic              m0_done,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [1:0]        m1_txn,
    output logic              m1_done,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    input  logic              data_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t            state;
    logic              last_grant;
    logic              gid;
    logic [1:0]        txn_q;
    logic [7:0]        wait_cnt;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [31:0]       rdata_q [2];

    logic              grant_valid;
    logic              grant_id;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_txn;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_id    = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_rw      = grant_id ? m1_rw    : m0_rw;
        sel_addr    = grant_id ? m1_addr  : m0_addr;
        sel_wdata   = grant_id ? m1_wdata : m0_wdata;
        sel_txn     = grant_id ? m1_txn   : m0_txn;
    end

    function automatic logic [31:0] mask_rd(input logic [1:0] t, input logic [31:0] d);
        case (t)
            2'b00:   mask_rd = {24'd0, d[7:0]};
            2'b01:   mask_rd = {16'd0, d[15:0]};
            default: mask_rd = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gid          <= 1'b0;
            txn_q        <= 2'b11;
            wait_cnt     <= 8'd0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= 32'd0;
            rdata_q[1]   <= 32'd0;
            address      <= '0;
            data_in      <= 32'd0;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
        end else begin
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gid        <= grant_id;
                        last_grant <= grant_id;
                        txn_q      <= sel_txn;
                        address    <= sel_addr;
                        if (sel_txn == 2'b11) begin
                            done_q[grant_id]  <= 1'b1;
                            err_q[grant_id]   <= 1'b1;
                            rdata_q[grant_id] <= 32'd0;
                            state             <= DONE;
                        end else if (sel_rw) begin
                            data_in      <= sel_wdata;
                            data_write_n <= sel_txn;
                            state        <= WR;
                        end else begin
                            data_read_n <= sel_txn;
                            wait_cnt    <= 8'd0;
                            state       <= RD;
                        end
                    end
                end
                WR: begin
                    data_write_n <= 2'b11;
                    done_q[gid]  <= 1'b1;
                    err_q[gid]   <= 1'b0;
                    state        <= DONE;
                end
                RD: begin
                    // A response arriving on the timeout cycle still counts as data.
                    if (data_ready) begin
                        data_read_n  <= 2'b11;
                        rdata_q[gid] <= mask_rd(txn_q, data_out);
                        done_q[gid]  <= 1'b1;
                        err_q[gid]   <= 1'b0;
                        state        <= DONE;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        data_read_n  <= 2'b11;
                        rdata_q[gid] <= 32'd0;
                        done_q[gid]  <= 1'b1;
                        err_q[gid]   <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // err is qualified by done so a stale flag never leaks outside the pulse.
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_err   = err_q[0] & done_q[0];
    assign m1_err   = err_q[1] & done_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign busy     = (state != IDLE);

endmodule
